// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants, hazard FSM states and a saturating counter helper
package core_pkg;

   localparam int REG_W    = 5;
   localparam int ZERO_REG = 31;

   typedef enum logic {
      RUN      = 1'b0,
      MUL_WAIT = 1'b1
   } hz_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
      return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
   endfunction

endpackage

// File: rtl/hazard_mul_timer.sv
// rtl/hazard_mul_timer.sv - multiply occupancy counter with load, zero detect and busy flag
module hazard_mul_timer #(
   parameter int MUL_LAT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic active,
   output logic zero,
   output logic busy
);

   localparam int CNT_W = $clog2(MUL_LAT);
   // The start cycle is already one hold cycle, and the zero-count cycle is the last one.
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MUL_LAT - 2);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (active && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);
   assign busy = active | load;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use, branch-flush and multiply-hold controller for the 5-stage pipe
// Optional macro HAZARD_PERF_EN adds saturating stall/flush performance counters.
module hazard_ctrl #(
   parameter int MUL_LAT  = 4,
   parameter int REG_W    = core_pkg::REG_W,
   parameter int ZERO_REG = core_pkg::ZERO_REG
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs_a,
   input  logic [REG_W-1:0] id_rs_b,
   input  logic             id_use_a,
   input  logic             id_use_b,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_we,
   input  logic             ex_is_load,
   input  logic             ex_mul_start,
   input  logic             br_taken,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             ex_hold,
   output logic             mul_busy
`ifdef HAZARD_PERF_EN
   ,
   output logic [15:0]      lu_stall_cnt,
   output logic [15:0]      flush_cnt,
   output logic [15:0]      mul_stall_cnt
`endif
);

   import core_pkg::*;

   hz_state_e state;
   logic      run;
   logic      mul_start;
   logic      lu;
   logic      t_zero;
   logic      t_busy;

   assign run       = (state == RUN);
   assign mul_start = run & ex_mul_start & ~br_taken;

   assign lu = ex_is_load & ex_we & (ex_rd != REG_W'(ZERO_REG)) &
               ((id_use_a & (id_rs_a == ex_rd)) | (id_use_b & (id_rs_b == ex_rd)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
      end else begin
         case (state)
            RUN:      if (mul_start) state <= MUL_WAIT;
            MUL_WAIT: if (t_zero)    state <= RUN;
         endcase
      end
   end

   hazard_mul_timer #(.MUL_LAT(MUL_LAT)) u_mul_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (mul_start),
      .active (~run),
      .zero   (t_zero),
      .busy   (t_busy)
   );

   always_comb begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      ex_hold     = 1'b0;
      mul_busy    = 1'b0;
      if (reset) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (!run || mul_start) begin
         // While EX is held, branch and load-use requests cannot be acted on.
         pc_we    = 1'b0;
         ifid_we  = 1'b0;
         ex_hold  = 1'b1;
         mul_busy = t_busy;
      end else if (br_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (lu) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_bubble = 1'b1;
      end
   end

`ifdef HAZARD_PERF_EN
   logic lu_stall_ev;
   logic flush_ev;

   assign lu_stall_ev = run & ~ex_mul_start & ~br_taken & lu;
   assign flush_ev    = run & br_taken;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lu_stall_cnt  <= '0;
         flush_cnt     <= '0;
         mul_stall_cnt <= '0;
      end else begin
         lu_stall_cnt  <= sat_inc16(lu_stall_cnt, lu_stall_ev);
         flush_cnt     <= sat_inc16(flush_cnt, flush_ev);
         mul_stall_cnt <= sat_inc16(mul_stall_cnt, ex_hold);
      end
   end
`endif

   assert property (@(posedge clk) disable iff (reset) !(ex_mul_start && br_taken));

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl against a cycle-level reference model
module tb_hazard_ctrl;

   localparam int MUL_LAT  = 4;
   localparam int REG_W    = 5;
   localparam int ZERO_REG = 31;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [REG_W-1:0] id_rs_a = '0;
   logic [REG_W-1:0] id_rs_b = '0;
   logic             id_use_a = 1'b0;
   logic             id_use_b = 1'b0;
   logic [REG_W-1:0] ex_rd = '0;
   logic             ex_we = 1'b0;
   logic             ex_is_load = 1'b0;
   logic             ex_mul_start = 1'b0;
   logic             br_taken = 1'b0;
   logic             pc_we, ifid_we, ifid_flush, idex_bubble, ex_hold, mul_busy;
`ifdef HAZARD_PERF_EN
   logic [15:0]      lu_stall_cnt, flush_cnt, mul_stall_cnt;
`endif

   always #5 clk = ~clk;

   hazard_ctrl #(.MUL_LAT(MUL_LAT), .REG_W(REG_W), .ZERO_REG(ZERO_REG)) dut (
      .clk          (clk),
      .reset        (reset),
      .id_rs_a      (id_rs_a),
      .id_rs_b      (id_rs_b),
      .id_use_a     (id_use_a),
      .id_use_b     (id_use_b),
      .ex_rd        (ex_rd),
      .ex_we        (ex_we),
      .ex_is_load   (ex_is_load),
      .ex_mul_start (ex_mul_start),
      .br_taken     (br_taken),
      .pc_we        (pc_we),
      .ifid_we      (ifid_we),
      .ifid_flush   (ifid_flush),
      .idex_bubble  (idex_bubble),
      .ex_hold      (ex_hold),
      .mul_busy     (mul_busy)
`ifdef HAZARD_PERF_EN
      ,
      .lu_stall_cnt (lu_stall_cnt),
      .flush_cnt    (flush_cnt),
      .mul_stall_cnt(mul_stall_cnt)
`endif
   );

   // Expected output vector: {pc_we, ifid_we, ifid_flush, idex_bubble, ex_hold, mul_busy}
   logic [5:0] exp_q[$];
   string      name_q[$];
   int         checks = 0;
   int         errors = 0;
   int         hold_left = 0;
   int         m_lu = 0, m_fl = 0, m_mul = 0;

   task automatic cycle(input string tag, input logic rst,
                        input logic [REG_W-1:0] rs_a, input logic [REG_W-1:0] rs_b,
                        input logic ua, input logic ub, input logic [REG_W-1:0] rd,
                        input logic we, input logic ld, input logic ms, input logic br);
      logic       hit;
      logic [5:0] e;
      @(posedge clk);
      #1;
      reset = rst; id_rs_a = rs_a; id_rs_b = rs_b; id_use_a = ua; id_use_b = ub;
      ex_rd = rd; ex_we = we; ex_is_load = ld; ex_mul_start = ms; br_taken = br;
      hit = ld && we && (rd != ZERO_REG) && ((ua && rs_a == rd) || (ub && rs_b == rd));
      if (rst) begin
         e = 6'b001100; hold_left = 0; m_lu = 0; m_fl = 0; m_mul = 0;
      end else if (hold_left > 0) begin
         e = 6'b000011; hold_left--; m_mul++;
      end else if (br) begin
         e = 6'b111100; m_fl++;
      end else if (ms) begin
         e = 6'b000011; hold_left = MUL_LAT - 1; m_mul++;
      end else if (hit) begin
         e = 6'b000100; m_lu++;
      end else begin
         e = 6'b110000;
      end
      exp_q.push_back(e);
      name_q.push_back(tag);
   endtask

   task automatic idle(input string tag);
      cycle(tag, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [5:0] e, got;
         string      n;
         e = exp_q.pop_front();
         n = name_q.pop_front();
         got = {pc_we, ifid_we, ifid_flush, idex_bubble, ex_hold, mul_busy};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL %s: got {pc_we,ifid_we,flush,bubble,hold,busy}=%b required %b at %0t",
                     n, got, e, $time);
         end
      end
   end

   function automatic logic [REG_W-1:0] pick_reg();
      int p;
      p = $urandom_range(0, 3);
      return (p == 3) ? REG_W'(ZERO_REG) : REG_W'(p + 1);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 3; i++) cycle("reset_state", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle("run_after_reset");
      // load-use on source A, then the load has moved on
      cycle("lu_stall", 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      idle("lu_release");
      cycle("zero_reg", 1'b0, 5'd31, 5'd0, 1'b1, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle("unused_b", 1'b0, 5'd0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle("no_load", 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle("lu_src_b", 1'b0, 5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle("br_over_lu", 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
      // multiply with an ignored branch and load-use inside the hold window
      cycle("mul_t0", 1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 0);
      cycle("mul_t1", 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle("mul_t2_br", 1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
      idle("mul_t3");
      idle("mul_t4_done");
      idle("mul_after");
      // reset during a multiply
      cycle("mul2_t0", 1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 0);
      cycle("mul2_reset", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle("mul2_reset_hold", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle("mul2_released");
      idle("mul2_run");

      for (int i = 0; i < 2000; i++) begin
         int r;
         logic ms, br, rst;
         r   = $urandom_range(0, 19);
         br  = (r < 3);
         ms  = (r >= 3 && r < 5);
         rst = ($urandom_range(0, 199) == 0);
         cycle("random", rst, pick_reg(), pick_reg(), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), pick_reg(), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), ms, br);
      end

      cycle("perf_reset", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle("perf_lu", 1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
         idle("perf_gap");
      end
      for (int i = 0; i < 2; i++) cycle("perf_br", 1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
      cycle("perf_mul", 1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
      for (int i = 0; i < MUL_LAT + 1; i++) idle("perf_tail");

      @(posedge clk);
      #1;
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
`ifdef HAZARD_PERF_EN
      checks++;
      if (lu_stall_cnt !== 16'd3) begin
         errors++;
         $display("FAIL lu_stall_cnt: got %0d required 3", lu_stall_cnt);
      end
      checks++;
      if (flush_cnt !== 16'd2) begin
         errors++;
         $display("FAIL flush_cnt: got %0d required 2", flush_cnt);
      end
      checks++;
      if (mul_stall_cnt !== 16'(MUL_LAT)) begin
         errors++;
         $display("FAIL mul_stall_cnt: got %0d required %0d", mul_stall_cnt, MUL_LAT);
      end
      checks++;
      if ({m_lu, m_fl, m_mul} !== {32'd3, 32'd2, 32'(MUL_LAT)}) begin
         errors++;
         $display("FAIL perf_model: model counts %0d %0d %0d", m_lu, m_fl, m_mul);
      end
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
